// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the arbiter state encoding and the port-index width function.
// Imported by the top and the round-robin sub-module.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_t;

   // Width of an index into n ports; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin pick: first requester searching upward from ptr+1, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is taken.
module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4
) (
   input  logic [NUM_PORTS-1:0]         req,
   input  logic [$clog2(NUM_PORTS)-1:0] ptr,
   output logic                         gnt_valid,
   output logic [$clog2(NUM_PORTS)-1:0] gnt_idx
);

   localparam int IDX_W = idx_width(NUM_PORTS);

   logic [IDX_W-1:0] cand;

   // Walk offsets from farthest to nearest so the port closest after ptr overrides the rest.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int off = NUM_PORTS; off >= 1; off--) begin
         cand = IDX_W'((int'(ptr) + off) % NUM_PORTS);
         if (req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_PORTS AXI-Stream sources, one whole packet per grant.
// Latency: 1 cycle arbitration, then optional header word, then zero-latency payload pass-through.
// Backpressure: m_axis_tready is forwarded only to the granted port in payload; all others see 0.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_PORTS     = 4,
   parameter int WORD_WIDTH    = 8,
   parameter int INSERT_HEADER = 1,
   parameter int HEADER_BASE   = 'hF0,
   parameter int MAX_BEATS     = 256
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS*WORD_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]            s_axis_tlast,
   output logic [NUM_PORTS-1:0]            s_axis_tready,
   output logic [WORD_WIDTH-1:0]           m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
   output logic                            busy,
   output logic                            overrun
);

   localparam int IDX_W = idx_width(NUM_PORTS);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  grant_id_q, grant_id_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic              busy_q, busy_d;
   logic              overrun_q, overrun_d;

   logic              gnt_valid;
   logic [IDX_W-1:0]  gnt_idx;

   logic [WORD_WIDTH-1:0] sel_dat;
   logic                  sel_vld;
   logic                  sel_lst;
   logic [WORD_WIDTH-1:0] hdr_dat;
   logic                  beat;

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS)
   ) u_rr (
      .req       (s_axis_tvalid),
      .ptr       (ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // Select the granted port's data, valid and last.
   always_comb begin
      sel_dat = '0;
      sel_vld = 1'b0;
      sel_lst = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_id_q == IDX_W'(i)) begin
            sel_dat = s_axis_tdata[i*WORD_WIDTH +: WORD_WIDTH];
            sel_vld = s_axis_tvalid[i];
            sel_lst = s_axis_tlast[i];
         end
      end
   end

   assign hdr_dat = WORD_WIDTH'(HEADER_BASE + int'(grant_id_q));
   assign beat    = (state_q == ST_PAYLOAD) && sel_vld && m_axis_tready;

   // Drive the stream outputs; rst forces everything quiet so no handshake happens during reset.
   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      s_axis_tready = '0;
      if (!rst) begin
         case (state_q)
            ST_HEADER: begin
               m_axis_tvalid = 1'b1;
               m_axis_tdata  = hdr_dat;
            end
            ST_PAYLOAD: begin
               m_axis_tvalid = sel_vld;
               m_axis_tdata  = sel_dat;
               for (int i = 0; i < NUM_PORTS; i++) begin
                  s_axis_tready[i] = (grant_id_q == IDX_W'(i)) && m_axis_tready;
               end
            end
            default: begin
               m_axis_tvalid = 1'b0;
            end
         endcase
      end
   end

   // Next-state logic: arbitrate in idle, emit header, pass payload until tlast or the beat limit.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
      beat_cnt_d = beat_cnt_q;
      overrun_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               grant_id_d = gnt_idx;
               beat_cnt_d = '0;
               state_d    = (INSERT_HEADER != 0) ? ST_HEADER : ST_PAYLOAD;
            end
         end
         ST_HEADER: begin
            if (m_axis_tready) begin
               beat_cnt_d = '0;
               state_d    = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (beat) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if (sel_lst) begin
                  state_d = ST_IDLE;
                  ptr_d   = grant_id_q;
               end else if (beat_cnt_q == LAST_CNT) begin
                  // Forced release: the remainder re-arbitrates as a fresh packet with a new header.
                  state_d   = ST_IDLE;
                  ptr_d     = grant_id_q;
                  overrun_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State registers with synchronous reset; ptr resets to the top port so port 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= IDX_W'(NUM_PORTS - 1);
         grant_id_q <= '0;
         beat_cnt_q <= '0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_id_q <= grant_id_d;
         beat_cnt_q <= beat_cnt_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
      end
   end

   assign grant_id = grant_id_q;
   assign busy     = busy_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single packet, rotation, backpressure, forced release, mid-packet reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, well before the rising edge.
// Uses MAX_BEATS=4 so the forced-release path is reachable with short packets.
module tb_uart_tx_arbiter;

   localparam int NP = 4;
   localparam int WW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP*WW-1:0]  s_tdata;
   logic [NP-1:0]     s_tvalid;
   logic [NP-1:0]     s_tlast;
   logic [NP-1:0]     s_tready;
   logic [WW-1:0]     m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic [1:0]        grant_id;
   logic              busy;
   logic              overrun;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_PORTS     (NP),
      .WORD_WIDTH    (WW),
      .INSERT_HEADER (1),
      .HEADER_BASE   ('hF0),
      .MAX_BEATS     (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .grant_id      (grant_id),
      .busy          (busy),
      .overrun       (overrun)
   );

   task automatic set_port(input int p, input logic [7:0] d, input logic v, input logic l);
      s_tdata[p*WW +: WW] = d;
      s_tvalid[p]         = v;
      s_tlast[p]          = l;
   endtask

   task automatic idle_inputs();
      s_tdata  = '0;
      s_tvalid = '0;
      s_tlast  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      m_tready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      m_tready = 1'b1;
      s_tdata  = 32'hA3A2A1A0;
      s_tvalid = 4'hF;
      s_tlast  = 4'hF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant c%0d: got %0d want 0", c, grant_id); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy c%0d: got %b want 0", c, busy); end
         total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun c%0d: got %b want 0", c, overrun); end
         total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_mvalid c%0d: got %b want 0", c, m_tvalid); end
         total++; if (s_tready !== 4'b0000) begin bad++; $display("FAIL reset_sready c%0d: got %b want 0000", c, s_tready); end
      end
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_single();
      logic [7:0] d [3]   = '{8'h11, 8'h22, 8'h33};
      logic [7:0] exp [4] = '{8'hF2, 8'h11, 8'h22, 8'h33};
      int p  = 0;
      int k  = 0;
      int bc = 0;
      int di;
      logic stray = 1'b0;
      m_tready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         di = (p < 3) ? p : 2;
         set_port(2, d[di], p < 3, p == 2);
         #1;
         if (m_tvalid && m_tready) begin
            total++;
            if (k >= 4) begin bad++; $display("FAIL single_extra: got %h want no word", m_tdata); end
            else if (m_tdata !== exp[k]) begin bad++; $display("FAIL single_word%0d: got %h want %h", k, m_tdata, exp[k]); end
            k++;
         end
         if (busy) bc++;
         if ((s_tready & 4'b1011) != 4'b0000) stray = 1'b1;
         if (s_tready[2] && s_tvalid[2]) p++;
      end
      total++; if (k != 4) begin bad++; $display("FAIL single_count: got %0d want 4", k); end
      total++; if (bc != 4) begin bad++; $display("FAIL single_busy_cycles: got %0d want 4", bc); end
      total++; if (stray !== 1'b0) begin bad++; $display("FAIL single_stray_ready: got %b want 0", stray); end
      total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL single_grant: got %0d want 2", grant_id); end
      idle_inputs();
   endtask

   task automatic test_round_robin();
      logic [7:0] exp [10] = '{8'hF0, 8'hA0, 8'hF1, 8'hA1, 8'hF2, 8'hA2, 8'hF3, 8'hA3, 8'hF0, 8'hA0};
      int k = 0;
      do_reset();
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         for (int i = 0; i < NP; i++) set_port(i, 8'hA0 + 8'(i), 1'b1, 1'b1);
         #1;
         total++;
         if (m_tvalid !== ((c % 3) != 0)) begin
            bad++; $display("FAIL rr_valid c%0d: got %b want %b", c, m_tvalid, ((c % 3) != 0));
         end
         if (m_tvalid && m_tready) begin
            total++;
            if (k >= 10) begin bad++; $display("FAIL rr_extra: got %h want no word", m_tdata); end
            else if (m_tdata !== exp[k]) begin bad++; $display("FAIL rr_word%0d: got %h want %h", k, m_tdata, exp[k]); end
            k++;
         end
      end
      @(negedge clk);
      idle_inputs();
      total++; if (k != 10) begin bad++; $display("FAIL rr_count: got %0d want 10", k); end
   endtask

   task automatic test_backpressure();
      logic [19:0] pat     = 20'hB6D35;
      logic [7:0]  d [4]   = '{8'h31, 8'h32, 8'h33, 8'h34};
      logic [7:0]  exp [5] = '{8'hF1, 8'h31, 8'h32, 8'h33, 8'h34};
      logic [3:0]  exp_rdy;
      logic        mbeat;
      int p = 0;
      int k = 0;
      int phase = 0;
      int di;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         m_tready = pat[c];
         di = (p < 4) ? p : 3;
         set_port(1, d[di], p < 4, p == 3);
         #1;
         exp_rdy = (phase == 2 && m_tready) ? 4'b0010 : 4'b0000;
         total++;
         if (s_tready !== exp_rdy) begin bad++; $display("FAIL bp_ready c%0d: got %b want %b", c, s_tready, exp_rdy); end
         if (m_tvalid && m_tready) begin
            total++;
            if (k >= 5) begin bad++; $display("FAIL bp_extra: got %h want no word", m_tdata); end
            else if (m_tdata !== exp[k]) begin bad++; $display("FAIL bp_word%0d: got %h want %h", k, m_tdata, exp[k]); end
            k++;
         end
         mbeat = (phase == 2) && s_tvalid[1] && m_tready;
         if (phase == 0 && s_tvalid[1]) phase = 1;
         else if (phase == 1 && m_tready) phase = 2;
         else if (mbeat) begin
            if (p == 3) phase = 0;
            p++;
         end
      end
      @(negedge clk);
      m_tready = 1'b1;
      idle_inputs();
      total++; if (k != 5) begin bad++; $display("FAIL bp_count: got %0d want 5", k); end
   endtask

   task automatic test_overrun();
      logic [7:0] d [6]   = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56};
      logic [7:0] exp [8] = '{8'hF0, 8'h51, 8'h52, 8'h53, 8'h54, 8'hF0, 8'h55, 8'h56};
      int p = 0;
      int k = 0;
      int di;
      m_tready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         di = (p < 6) ? p : 5;
         set_port(0, d[di], p < 6, p == 5);
         #1;
         total++;
         if (overrun !== (c == 6)) begin bad++; $display("FAIL ovr_pulse c%0d: got %b want %b", c, overrun, (c == 6)); end
         if (c == 6) begin
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_busy: got %b want 0", busy); end
         end
         if (m_tvalid && m_tready) begin
            total++;
            if (k >= 8) begin bad++; $display("FAIL ovr_extra: got %h want no word", m_tdata); end
            else if (m_tdata !== exp[k]) begin bad++; $display("FAIL ovr_word%0d: got %h want %h", k, m_tdata, exp[k]); end
            k++;
         end
         if (s_tready[0] && s_tvalid[0]) p++;
      end
      idle_inputs();
      total++; if (k != 8) begin bad++; $display("FAIL ovr_count: got %0d want 8", k); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL ovr_grant: got %0d want 0", grant_id); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d [5] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
      int p = 0;
      m_tready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         set_port(2, d[p], 1'b1, p == 4);
         #1;
         if (c == 2) begin
            total++; if (m_tdata !== 8'h61) begin bad++; $display("FAIL mid_first_beat: got %h want 61", m_tdata); end
         end
         if (s_tready[2] && s_tvalid[2]) p++;
      end
      total++; if (p != 2) begin bad++; $display("FAIL mid_beats_before_reset: got %0d want 2", p); end
      @(negedge clk);
      rst = 1'b1;
      set_port(2, d[p], 1'b1, 1'b0);
      #1;
      total++; if (s_tready !== 4'b0000) begin bad++; $display("FAIL mid_rst_ready: got %b want 0000", s_tready); end
      total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_mvalid: got %b want 0", m_tvalid); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NP; i++) set_port(i, 8'hA0 + 8'(i), 1'b1, 1'b1);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_after: got %b want 0", busy); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL mid_grant_after: got %0d want 0", grant_id); end
      total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_mvalid_after: got %b want 0", m_tvalid); end
      @(negedge clk);
      #1;
      total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL mid_hdr_valid: got %b want 1", m_tvalid); end
      total++; if (m_tdata !== 8'hF0) begin bad++; $display("FAIL mid_hdr_data: got %h want F0", m_tdata); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL mid_hdr_grant: got %0d want 0", grant_id); end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_overrun();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
